// File: rtl/tmd4_exec_if.sv
// TMD4 execute-stage bus: decoder/ROM-side controls in, architectural state out.
// The master side (decoder, or the bench) drives ce/sel/load_n/imm/in_port.
// The slave side (tmd4_exec) drives the register outputs and flags.
interface tmd4_exec_if #(
    parameter int WIDTH = 4
) ();
    logic             ce;
    logic [1:0]       sel;
    logic [3:0]       load_n;
    logic [WIDTH-1:0] imm;
    logic [WIDTH-1:0] in_port;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] out_port;
    logic [WIDTH-1:0] pc;
    logic             carry;
    logic             halted;

    modport master (
        output ce, sel, load_n, imm, in_port,
        input  a, b, out_port, pc, carry, halted
    );

    modport slave (
        input  ce, sel, load_n, imm, in_port,
        output a, b, out_port, pc, carry, halted
    );
endinterface

// File: rtl/tmd4_exec.sv
// TMD4 execute/register stage.
// Holds A, B, OUT, PC and the carry flag. Each enabled cycle one source
// (A, B, in_port or zero) is added to the immediate and the sum is written to
// every register whose load_n bit is low; PC otherwise increments.
// Optional build macro TMD4_HALT_EN: a jump to the current PC latches
// `halted`, which freezes all state until rst_n is asserted. Without the
// macro `halted` is constant 0.
module tmd4_exec #(
    parameter int WIDTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    tmd4_exec_if.slave bus
);

    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] out_r;
    logic [WIDTH-1:0] pc_r;
    logic             carry_r;
    logic             halted_r;

    logic [WIDTH-1:0] src_s;
    logic [WIDTH-1:0] sum_s;
    logic             cout_s;
    logic             upd_s;

    // ALU source select: A, B, external switches or zero.
    always_comb begin
        src_s = {WIDTH{1'b0}};
        case (bus.sel)
            2'b00:   src_s = a_r;
            2'b01:   src_s = b_r;
            2'b10:   src_s = bus.in_port;
            2'b11:   src_s = {WIDTH{1'b0}};
            default: src_s = {WIDTH{1'b0}};
        endcase
    end

    // Adder with carry-out and no carry-in.
    always_comb begin
        {cout_s, sum_s} = {1'b0, src_s} + {1'b0, bus.imm};
    end

`ifdef TMD4_HALT_EN
    // Once halted, the instruction strobe is ignored so all state is frozen.
    assign upd_s = bus.ce & ~halted_r;

    // Jump-to-self detection; only reset clears the halt flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            halted_r <= 1'b0;
        end else if (upd_s && !bus.load_n[3] && (sum_s == pc_r)) begin
            halted_r <= 1'b1;
        end else begin
            halted_r <= halted_r;
        end
    end
`else
    assign upd_s    = bus.ce;
    assign halted_r = 1'b0;
`endif

    // Register A: loads the sum when selected on an enabled cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r <= {WIDTH{1'b0}};
        end else if (upd_s && !bus.load_n[0]) begin
            a_r <= sum_s;
        end else begin
            a_r <= a_r;
        end
    end

    // Register B: loads the sum when selected on an enabled cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b_r <= {WIDTH{1'b0}};
        end else if (upd_s && !bus.load_n[1]) begin
            b_r <= sum_s;
        end else begin
            b_r <= b_r;
        end
    end

    // OUT register driving the LEDs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_r <= {WIDTH{1'b0}};
        end else if (upd_s && !bus.load_n[2]) begin
            out_r <= sum_s;
        end else begin
            out_r <= out_r;
        end
    end

    // Program counter: jump target when selected, else increment with wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_r <= {WIDTH{1'b0}};
        end else if (upd_s) begin
            if (!bus.load_n[3]) begin
                pc_r <= sum_s;
            end else begin
                pc_r <= pc_r + {{(WIDTH-1){1'b0}}, 1'b1};
            end
        end else begin
            pc_r <= pc_r;
        end
    end

    // Carry flag follows the adder on every enabled cycle, jumps included.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            carry_r <= 1'b0;
        end else if (upd_s) begin
            carry_r <= cout_s;
        end else begin
            carry_r <= carry_r;
        end
    end

    assign bus.a        = a_r;
    assign bus.b        = b_r;
    assign bus.out_port = out_r;
    assign bus.pc       = pc_r;
    assign bus.carry    = carry_r;
    assign bus.halted   = halted_r;

endmodule

// File: tb/tb_tmd4_exec.sv
// Bench for tmd4_exec: directed instruction vectors push hand-computed
// expected state into a scoreboard queue; an independent monitor pops one
// entry after each rising edge (or after an asynchronous reset strobe) and
// compares it with the DUT outputs.
module tb_tmd4_exec;

`ifdef TMD4_HALT_EN
    localparam logic HALT_ON = 1'b1;
`else
    localparam logic HALT_ON = 1'b0;
`endif

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] o;
        logic [3:0] pc;
        logic       c;
        logic       h;
        string      nm;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;
    exp_t sb_q[$];
    event async_chk;

    tmd4_exec_if #(.WIDTH(4)) bus ();

    tmd4_exec #(.WIDTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cmp(input string nm, input string fld, input logic [3:0] act, input logic [3:0] exp_v);
        n_checks = n_checks + 1;
        if (act !== exp_v) begin
            n_fail = n_fail + 1;
            $display("FAIL %s.%s: got %0d expected %0d", nm, fld, act, exp_v);
        end
    endtask

    // Monitor: one scoreboard entry per rising edge or async-reset strobe.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk or async_chk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                cmp(e.nm, "a",      bus.a,              e.a);
                cmp(e.nm, "b",      bus.b,              e.b);
                cmp(e.nm, "out",    bus.out_port,       e.o);
                cmp(e.nm, "pc",     bus.pc,             e.pc);
                cmp(e.nm, "carry",  {3'b000, bus.carry},  {3'b000, e.c});
                cmp(e.nm, "halted", {3'b000, bus.halted}, {3'b000, e.h});
            end
        end
    end

    task automatic push(input logic [3:0] ea, input logic [3:0] eb, input logic [3:0] eo,
                        input logic [3:0] epc, input logic ec, input logic eh, input string nm);
        exp_t e;
        e.a = ea; e.b = eb; e.o = eo; e.pc = epc; e.c = ec; e.h = eh; e.nm = nm;
        sb_q.push_back(e);
    endtask

    // Drive one instruction after the falling edge; expectation is for after the next rising edge.
    task automatic step(input logic ce_v, input logic [1:0] sel_v, input logic [3:0] ld_v,
                        input logic [3:0] imm_v, input logic [3:0] in_v,
                        input logic [3:0] ea, input logic [3:0] eb, input logic [3:0] eo,
                        input logic [3:0] epc, input logic ec, input logic eh, input string nm);
        @(negedge clk);
        bus.ce      = ce_v;
        bus.sel     = sel_v;
        bus.load_n  = ld_v;
        bus.imm     = imm_v;
        bus.in_port = in_v;
        push(ea, eb, eo, epc, ec, eh, nm);
    endtask

    // Assert reset between edges and check all outputs clear before the next edge.
    task automatic async_reset(input string nm);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        push(4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, nm);
        -> async_chk;
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n  = 1'b1;
        bus.ce = 1'b0;
    endtask

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        rst_n       = 1'b0;
        bus.ce      = 1'b0;
        bus.sel     = 2'b11;
        bus.load_n  = 4'b1111;
        bus.imm     = 4'd0;
        bus.in_port = 4'd0;

        #2;
        push(4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, "reset_state");
        -> async_chk;
        // Enabled instructions during reset must not update anything.
        step(1'b1, 2'b11, 4'b0000, 4'd5, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, "in_reset");
        release_reset();

        // PC counts and wraps with no flag.
        for (int i = 1; i <= 16; i++) begin
            step(1'b1, 2'b11, 4'b1111, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'(i), 1'b0, 1'b0, "pc_count");
        end

        step(1'b1, 2'b11, 4'b1110, 4'd5,  4'd0,  4'd5, 4'd0, 4'd0, 4'd1, 1'b0, 1'b0, "mov_a5");
        step(1'b1, 2'b00, 4'b1110, 4'd12, 4'd0,  4'd1, 4'd0, 4'd0, 4'd2, 1'b1, 1'b0, "add_a12");
        step(1'b1, 2'b11, 4'b1111, 4'd0,  4'd0,  4'd1, 4'd0, 4'd0, 4'd3, 1'b0, 1'b0, "nop_clr_c");
        step(1'b1, 2'b10, 4'b1101, 4'd0,  4'd9,  4'd1, 4'd9, 4'd0, 4'd4, 1'b0, 1'b0, "in_b");
        step(1'b1, 2'b01, 4'b1011, 4'd0,  4'd0,  4'd1, 4'd9, 4'd9, 4'd5, 1'b0, 1'b0, "out_b");
        step(1'b0, 2'b11, 4'b0000, 4'd7,  4'd0,  4'd1, 4'd9, 4'd9, 4'd5, 1'b0, 1'b0, "ce_low");
        // All four targets load the same sum: 15+3 = 18 -> 2, carry 1.
        step(1'b1, 2'b10, 4'b0000, 4'd3,  4'd15, 4'd2, 4'd2, 4'd2, 4'd2, 1'b1, 1'b0, "multi_load");
        for (int i = 3; i <= 7; i++) begin
            step(1'b1, 2'b11, 4'b1111, 4'd0, 4'd0, 4'd2, 4'd2, 4'd2, 4'(i), 1'b0, 1'b0, "nop_to7");
        end
        // Jump from 7 to 3 with carry out: 15+4 = 19 -> 3, carry 1.
        step(1'b1, 2'b10, 4'b0111, 4'd4,  4'd15, 4'd2, 4'd2, 4'd2, 4'd3, 1'b1, 1'b0, "jmp3");
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 2'b11, 4'b0000, 4'd0, 4'd0, 4'd2, 4'd2, 4'd2, 4'd3, 1'b1, 1'b0, "hold10");
        end
        step(1'b1, 2'b11, 4'b1110, 4'd5,  4'd0,  4'd5, 4'd2, 4'd2, 4'd4, 1'b0, 1'b0, "mov_a5_b");
        step(1'b1, 2'b11, 4'b0111, 4'd3,  4'd0,  4'd5, 4'd2, 4'd2, 4'd3, 1'b0, 1'b0, "jmp3_b");

        async_reset("async_rst1");
        step(1'b1, 2'b11, 4'b0000, 4'd5, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, "rst_hold");
        release_reset();

        // Jump-to-self at pc 6.
        for (int i = 1; i <= 6; i++) begin
            step(1'b1, 2'b11, 4'b1111, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'(i), 1'b0, 1'b0, "nop_to6");
        end
        step(1'b1, 2'b11, 4'b0111, 4'd6, 4'd0, 4'd0, 4'd0, 4'd0, 4'd6, 1'b0, HALT_ON, "jmp_self");
        step(1'b1, 2'b11, 4'b0111, 4'd6, 4'd0, 4'd0, 4'd0, 4'd0, 4'd6, 1'b0, HALT_ON, "jmp_self2");
        for (int i = 1; i <= 3; i++) begin
            if (HALT_ON) begin
                step(1'b1, 2'b11, 4'b1110, 4'd9, 4'd0, 4'd0, 4'd0, 4'd0, 4'd6, 1'b0, 1'b1, "halted_frz");
            end else begin
                step(1'b1, 2'b11, 4'b1110, 4'd9, 4'd0, 4'd9, 4'd0, 4'd0, 4'(6 + i), 1'b0, 1'b0, "no_halt");
            end
        end

        async_reset("async_rst2");
        release_reset();
        step(1'b1, 2'b11, 4'b1111, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd1, 1'b0, 1'b0, "after_rst2");

        // Bounded drain of the scoreboard.
        for (int i = 0; i < 20; i++) begin
            if (sb_q.size() == 0) break;
            @(posedge clk);
            #2;
        end
        n_checks = n_checks + 1;
        if (sb_q.size() != 0) begin
            n_fail = n_fail + 1;
            $display("FAIL drain: got %0d pending entries expected 0", sb_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tmd4_exec.md
Name: tmd4_exec

Overview:
- Execute/register stage of the TMD4 4-bit CPU. Sits directly downstream of the instruction decoder `id` and consumes its `sel` and `load_n` outputs.
- Holds the architectural state: A, B, OUT and PC registers plus the carry flag.
- Per enabled cycle: selects one ALU source via `sel`, adds the 4-bit immediate, and writes the sum into the register(s) whose `load_n` bit is low.
- Feeds `carry` back to `id` for conditional jumps, and `pc` to the program ROM.

Parameters:
- WIDTH, 4, data/address width of A, B, OUT, PC, immediate and input port; fixed at 4 for the ISA, parameterised for the bench only.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- ce  input  1  clock enable / instruction strobe from the clock divider or single-step logic; state updates only when 1.
- sel  input  2  ALU source select from `id`: 00=A, 01=B, 10=in_port, 11=zero.
- load_n  input  4  active-low register loads from `id`: [0]=A, [1]=B, [2]=OUT, [3]=PC.
- imm  input  WIDTH  immediate field (instruction low nibble) from ROM.
- in_port  input  WIDTH  external input switches; sampled combinationally through the mux.
- a  output  WIDTH  register A.
- b  output  WIDTH  register B.
- out_port  output  WIDTH  OUT register, drives LEDs.
- pc  output  WIDTH  program counter, ROM address.
- carry  output  1  carry flag to `id`.
- halted  output  1  halt status; tied 0 unless TMD4_HALT_EN is defined.

Behaviour:
- Reset (rst_n=0, asynchronous, any time including mid-instruction): a, b, out_port and pc go to 0; carry=0; halted=0. Outputs stay there while rst_n=0. The first update happens on the first clk rising edge with ce=1 after release.
- Source mux: src = A/B/in_port/0 per `sel`; purely combinational.
- Adder: {cout, sum} = src + imm, WIDTH+1 bits, no carry-in.
- On each rising clk edge with ce=1, all updates take effect simultaneously, one-cycle latency:
  - load_n[0]=0 -> a<=sum; load_n[1]=0 -> b<=sum; load_n[2]=0 -> out_port<=sum.
  - load_n[3]=0 -> pc<=sum (jump); otherwise pc<=pc+1, with wrap 15->0 and no flag.
  - carry<=cout every enabled cycle, regardless of load_n. JMP/JNC instructions therefore also update carry; this is the TD4 semantic.
- Registers with load_n bit high hold their value.
- Multiple load_n bits low at once: every selected register loads the same sum. This is legal and must not glitch.
- load_n=4'b1111 (no target): only the pc increment and carry update occur.
- ce=0: all state holds, including pc and carry, regardless of the other inputs.
- ce, sel, load_n and imm are synchronous inputs and must be stable at the edge. in_port is async to the design; no synchroniser is included in this block.

Optional Feature:
- Macro: TMD4_HALT_EN.
- Defined:
  - Jump-to-self detection. An enabled cycle with load_n[3]=0 and sum==pc sets halted<=1 at that edge; pc keeps its value.
  - While halted=1, ce is ignored and all state is frozen, carry included.
  - Only rst_n clears halted.
- Undefined: halted is constant 0 and jump-to-self simply loops forever.

Test Plan:
- Reset then ce pulses with load_n=1111, imm=0 -> pc counts 0,1,...,15,0; carry stays 0; a, b, out_port stay 0.
- sel=11, imm=5, load_n=1110 (MOV A,5), then sel=00, imm=12, load_n=1110 (ADD A,12) -> a=5, then a=1 with carry=1. Next instruction, imm=0 NOP-type -> carry=0.
- sel=10, in_port=9, imm=0, load_n=1101 (IN B) -> b=9. Then sel=01, imm=0, load_n=1011 (OUT B) -> out_port=9.
- sel=11, imm=3, load_n=0111 (JMP 3) with pc=7 -> pc=3 next edge. Hold ce=0 for 10 cycles -> pc stays 3, carry unchanged.
- Assert rst_n low asynchronously between edges with a=5, pc=3 -> all outputs 0 immediately, before the next clk edge.
- With TMD4_HALT_EN, at pc=6 apply sel=11, imm=6, load_n=0111 -> halted=1, pc=6. Further ce pulses with load_n=1110 leave a unchanged. Without the macro, the same stimulus leaves halted=0 and pc=6 each cycle.
